// File: rtl/ram_bist_pkg.sv
// Shared types and March C- element tables for the RAM BIST initiator.
// Elements are described by direction, read/write presence and fill bits.
package ram_bist_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [2:0] E0 = 3'd0;
   localparam logic [2:0] E1 = 3'd1;
   localparam logic [2:0] E2 = 3'd2;
   localparam logic [2:0] E3 = 3'd3;
   localparam logic [2:0] E4 = 3'd4;
   localparam logic [2:0] E5 = 3'd5;

   // Fill bits; replicated to the RAM word width by the user.
   localparam logic ALL0 = 1'b0;
   localparam logic ALL1 = 1'b1;

   typedef struct packed {
      logic up;
      logic rexp;
      logic wval;
      logic has_rd;
      logic has_wr;
   } elem_cfg_t;

   function automatic elem_cfg_t elem_cfg(input logic [2:0] e);
      elem_cfg_t c;
      case (e)
         E0: c = '{up: 1'b1, rexp: ALL0, wval: ALL0,
                   has_rd: 1'b0, has_wr: 1'b1};
         E1: c = '{up: 1'b1, rexp: ALL0, wval: ALL1,
                   has_rd: 1'b1, has_wr: 1'b1};
         E2: c = '{up: 1'b1, rexp: ALL1, wval: ALL0,
                   has_rd: 1'b1, has_wr: 1'b1};
         E3: c = '{up: 1'b0, rexp: ALL0, wval: ALL1,
                   has_rd: 1'b1, has_wr: 1'b1};
         E4: c = '{up: 1'b0, rexp: ALL1, wval: ALL0,
                   has_rd: 1'b1, has_wr: 1'b1};
         default: c = '{up: 1'b1, rexp: ALL0, wval: ALL0,
                        has_rd: 1'b1, has_wr: 1'b0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Loadable up/down address counter for the march walker.
// at_last_o flags the final address in the current direction.
module march_addr_gen #(
   parameter int ADD_W = 4,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [ADD_W-1:0] load_val_i,
   input  logic             step_i,
   input  logic             up_i,
   output logic [ADD_W-1:0] addr_o,
   output logic             at_last_o
);

   logic [ADD_W-1:0] addr_q, addr_d;

   always_comb begin
      addr_d = addr_q;
      if (load_i) begin
         addr_d = load_val_i;
      end else if (step_i) begin
         addr_d = up_i ? addr_q + ADD_W'(1)
                       : addr_q - ADD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr_o    = addr_q;
   assign at_last_o = up_i ? (addr_q == ADD_W'(DEPTH - 1))
                           : (addr_q == '0);

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST initiator: one RAM op per cycle, 1-deep compare pipe,
// first-mismatch capture and pass/done reporting.
module ram_march_bist #(
   parameter int ADD_W  = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2**ADD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADD_W-1:0]  mem_rd_add,
   output logic [ADD_W-1:0]  mem_wr_add,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADD_W-1:0]  fail_add,
   output logic [2:0]        fail_elem,
   output logic [DATA_W-1:0] fail_data
);
   import ram_bist_pkg::*;

   state_t            state_q, state_d;
   logic [2:0]        elem_q, elem_d;
   logic              ph_q, ph_d;
   logic              rd_q, rd_d, wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              pass_q, pass_d;
   logic [ADD_W-1:0]  fadd_q, fadd_d;
   logic [2:0]        felem_q, felem_d;
   logic [DATA_W-1:0] fdata_q, fdata_d;
   logic              xv_q, xv_d;
   logic [DATA_W-1:0] xdat_q, xdat_d;
   logic [ADD_W-1:0]  xadd_q, xadd_d;
   logic [2:0]        xelem_q, xelem_d;

   logic              ld, step, up, at_last, mism;
   logic [ADD_W-1:0]  ld_val, addr;
   elem_cfg_t         cur, nxt;

   march_addr_gen #(.ADD_W(ADD_W), .DEPTH(DEPTH)) u_addr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ld),
      .load_val_i (ld_val),
      .step_i     (step),
      .up_i       (up),
      .addr_o     (addr),
      .at_last_o  (at_last)
   );

   assign mism = xv_q && (mem_rdata != xdat_q);

   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      ph_d    = ph_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      fadd_d  = fadd_q;
      felem_d = felem_q;
      fdata_d = fdata_q;
      xv_d    = 1'b0;
      xdat_d  = xdat_q;
      xadd_d  = xadd_q;
      xelem_d = xelem_q;
      ld      = 1'b0;
      ld_val  = '0;
      step    = 1'b0;
      cur     = elem_cfg(elem_q);
      nxt     = cur;
      up      = cur.up;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               nxt     = elem_cfg(E0);
               state_d = S_RUN;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               fadd_d  = '0;
               felem_d = '0;
               fdata_d = '0;
               elem_d  = E0;
               ph_d    = 1'b0;
               ld      = 1'b1;
               rd_d    = 1'b0;
               wr_d    = 1'b1;
               wdata_d = {DATA_W{nxt.wval}};
            end
         end
         S_RUN: begin
            if (rd_q) begin
               xv_d    = 1'b1;
               xdat_d  = {DATA_W{cur.rexp}};
               xadd_d  = addr;
               xelem_d = elem_q;
            end
            if (mism) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = 1'b0;
               fadd_d  = xadd_q;
               felem_d = xelem_q;
               fdata_d = mem_rdata;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               xv_d    = 1'b0;
            end else begin
               if (cur.has_rd && cur.has_wr && !ph_q) begin
                  ph_d = 1'b1;
               end else if (!at_last) begin
                  step = 1'b1;
                  ph_d = 1'b0;
               end else if (elem_q == E5) begin
                  state_d = S_DRAIN;
               end else begin
                  // Next element starts where its direction begins.
                  elem_d = elem_q + 3'd1;
                  ph_d   = 1'b0;
                  ld     = 1'b1;
                  nxt    = elem_cfg(elem_d);
                  ld_val = nxt.up ? '0 : ADD_W'(DEPTH - 1);
               end
               nxt     = elem_cfg(elem_d);
               rd_d    = (state_d == S_RUN) && nxt.has_rd && !ph_d;
               wr_d    = (state_d == S_RUN) && !rd_d;
               wdata_d = wr_d ? {DATA_W{nxt.wval}} : '0;
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = !mism;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            if (mism) begin
               fadd_d  = xadd_q;
               felem_d = xelem_q;
               fdata_d = mem_rdata;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         elem_q  <= '0;
         ph_q    <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fadd_q  <= '0;
         felem_q <= '0;
         fdata_q <= '0;
         xv_q    <= 1'b0;
         xdat_q  <= '0;
         xadd_q  <= '0;
         xelem_q <= '0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         ph_q    <= ph_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fadd_q  <= fadd_d;
         felem_q <= felem_d;
         fdata_q <= fdata_d;
         xv_q    <= xv_d;
         xdat_q  <= xdat_d;
         xadd_q  <= xadd_d;
         xelem_q <= xelem_d;
      end
   end

   assign mem_read   = rd_q;
   assign mem_write  = wr_q;
   assign mem_rd_add = addr;
   assign mem_wr_add = addr;
   assign mem_wdata  = wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail_add   = fadd_q;
   assign fail_elem  = felem_q;
   assign fail_data  = fdata_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Scoreboard bench for ram_march_bist: behavioural RAM with stuck-at
// faults, reference march walker, decoupled op/result monitor.
module tb_ram_march_bist;

   typedef struct {
      bit         rd;
      bit         wr;
      logic [3:0] a;
      logic [7:0] d;
      int         cyc;
   } op_t;

   typedef struct {
      bit         pass;
      logic [3:0] a;
      logic [2:0] e;
      logic [7:0] d;
      int         cyc;
   } res_t;

   // Per-element properties indexed by element number 0..5.
   localparam bit [5:0] DESC = 6'b011000;
   localparam bit [5:0] RD   = 6'b111110;
   localparam bit [5:0] WR   = 6'b011111;
   localparam bit [5:0] REXP = 6'b010100;
   localparam bit [5:0] WVAL = 6'b001010;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       mem_read, mem_write;
   logic [3:0] mem_rd_add, mem_wr_add;
   logic [7:0] mem_wdata, mem_rdata;
   logic       busy, done, pass;
   logic [3:0] fail_add;
   logic [2:0] fail_elem;
   logic [7:0] fail_data;

   int         cyc = 0;
   int         n_vec = 0;
   int         n_err = 0;
   bit         done_prev = 1'b0;
   op_t        opq[$];
   res_t       resq[$];

   logic [7:0] ram [16];
   bit         f_en = 1'b0;
   logic [3:0] f_add = '0;
   logic [7:0] f_mask = '0;
   bit         f_val = 1'b0;

   ram_march_bist dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_rd_add (mem_rd_add),
      .mem_wr_add (mem_wr_add),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .fail_add   (fail_add),
      .fail_elem  (fail_elem),
      .fail_data  (fail_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] rd_fault(input logic [7:0] v,
                                           input logic [3:0] a);
      if (f_en && a == f_add)
         return f_val ? (v | f_mask) : (v & ~f_mask);
      return v;
   endfunction

   always @(posedge clk) begin
      if (mem_write) ram[mem_wr_add] <= mem_wdata;
      if (mem_read) mem_rdata <= rd_fault(ram[mem_rd_add], mem_rd_add);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // Reference walk of March C- over a 16-word memory with the fault.
   task automatic build_expect(input int k);
      logic [7:0] m [16];
      op_t        ops[$];
      op_t        o;
      res_t       r;
      logic [7:0] v;
      int         c = 0;
      int         fc = 0;
      int         n;
      r.pass = 1'b1;
      r.a = '0;
      r.e = '0;
      r.d = '0;
      for (int e = 0; e < 6; e++) begin
         for (int j = 0; j < 16; j++) begin
            int a;
            a = DESC[e] ? 15 - j : j;
            if (RD[e]) begin
               c++;
               v = rd_fault(m[a], a[3:0]);
               o.rd = 1'b1; o.wr = 1'b0; o.a = a[3:0];
               o.d = 8'h00; o.cyc = k + c - 1;
               ops.push_back(o);
               if (fc == 0 && v !== {8{REXP[e]}}) begin
                  fc = c;
                  r.pass = 1'b0;
                  r.a = a[3:0];
                  r.e = e[2:0];
                  r.d = v;
               end
            end
            if (WR[e]) begin
               c++;
               m[a] = {8{WVAL[e]}};
               o.rd = 1'b0; o.wr = 1'b1; o.a = a[3:0];
               o.d = m[a]; o.cyc = k + c - 1;
               ops.push_back(o);
            end
         end
      end
      n = (fc == 0) ? c : ((fc + 1 < c) ? fc + 1 : c);
      for (int i = 0; i < n; i++) opq.push_back(ops[i]);
      r.cyc = (fc == 0) ? k + c + 1 : k + fc + 1;
      resq.push_back(r);
   endtask

   always @(negedge clk) begin
      op_t  o;
      res_t r;
      if (mem_read || mem_write) begin
         if (opq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_op: got rd=%0b wr=%0b add=%0h, want none",
                     mem_read, mem_write, mem_rd_add);
         end else begin
            o = opq.pop_front();
            chk("op_rd", mem_read, o.rd);
            chk("op_wr", mem_write, o.wr);
            chk("op_rd_add", mem_rd_add, o.a);
            chk("op_wr_add", mem_wr_add, o.a);
            if (o.wr) chk("op_wdata", mem_wdata, o.d);
            chk("op_cycle", cyc, o.cyc);
         end
      end
      if (done && !done_prev) begin
         if (resq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1, want 0");
         end else begin
            r = resq.pop_front();
            chk("pass", pass, r.pass);
            chk("fail_add", fail_add, r.a);
            chk("fail_elem", fail_elem, r.e);
            chk("fail_data", fail_data, r.d);
            chk("done_cycle", cyc, r.cyc);
            chk("busy_at_done", busy, 0);
            chk("strobes_at_done", {mem_read, mem_write}, 0);
         end
      end
      done_prev = done;
   end

   task automatic run_test(input bit fen, input logic [3:0] fa,
                           input int fb, input bit fv, input bit pulses);
      int k;
      bit got = 1'b0;
      @(negedge clk);
      f_en = fen;
      f_add = fa;
      f_mask = 8'h01 << fb;
      f_val = fv;
      k = cyc + 1;
      build_expect(k);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_done", done, 0);
      chk("start_pass", pass, 0);
      chk("start_fail_clr", {fail_add, fail_elem, fail_data}, 0);
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            start = 1'b0;
         end else begin
            start = pulses && busy && ($urandom_range(0, 3) == 0);
         end
      end
      start = 1'b0;
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL done_timeout: got done=0, want 1");
      end
      repeat (2) @(negedge clk);
      chk("ops_left", opq.size(), 0);
      chk("results_left", resq.size(), 0);
      opq.delete();
      resq.delete();
      if (!fen) begin
         for (int i = 0; i < 16; i++) chk("ram_final", ram[i], 0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int strobes;
      bit  fen, fv, pl;
      for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
      mem_rdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_status", {busy, done, pass, mem_read, mem_write,
                         fail_add, fail_elem, fail_data}, 0);
      chk("rst_bus", {mem_rd_add, mem_wr_add, mem_wdata}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_test(1'b0, 4'd0, 0, 1'b0, 1'b0);
      run_test(1'b1, 4'd5, 3, 1'b1, 1'b0);
      run_test(1'b0, 4'd0, 0, 1'b0, 1'b0);
      run_test(1'b1, 4'd10, 0, 1'b0, 1'b0);
      run_test(1'b0, 4'd0, 0, 1'b0, 1'b1);

      @(negedge clk);
      f_en = 1'b0;
      k = cyc + 1;
      build_expect(k);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < k + 49) @(negedge clk);
      #1;
      opq.delete();
      resq.delete();
      rst = 1'b1;
      @(negedge clk);
      chk("abort_status", {busy, done, pass, mem_read, mem_write,
                           fail_add, fail_elem, fail_data}, 0);
      chk("abort_bus", {mem_rd_add, mem_wr_add, mem_wdata}, 0);
      rst = 1'b0;
      strobes = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_read || mem_write) strobes++;
      end
      chk("abort_no_strobe", strobes, 0);
      run_test(1'b0, 4'd0, 0, 1'b0, 1'b0);

      for (int t = 0; t < 6; t++) begin
         fen = 1'($urandom_range(0, 1));
         fv  = 1'($urandom_range(0, 1));
         pl  = 1'($urandom_range(0, 1));
         run_test(fen, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 7)), fv, pl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
